// File: rtl/popcnt_seq_pkg.sv
// popcnt_seq_pkg: shared FSM state type and chunk sizing for the sequential popcount.
package popcnt_seq_pkg;
    localparam int CHUNK = 32;
    localparam int CNT_W = 7;
    localparam int PC_W = $clog2(CHUNK + 1);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
endpackage

// File: rtl/popcnt_seq_if.sv
// popcnt_seq_if: request/response handshake bundle between a requester and popcnt_seq.
interface popcnt_seq_if #(parameter int XLEN = 64);
    logic ValidIn, ReadyOut, Word, Flush, ValidOut, ReadyIn, Busy;
    logic [XLEN-1:0] A;
    logic [6:0] Result;
    modport master(output ValidIn, A, Word, Flush, ReadyIn, input ReadyOut, ValidOut, Result, Busy);
    modport slave(input ValidIn, A, Word, Flush, ReadyIn, output ReadyOut, ValidOut, Result, Busy);
endinterface

// File: rtl/popcnt_seq_popcnt.sv
// popcnt: combinational population count of a WIDTH-bit word.
module popcnt #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0]               x_i,
    output logic [$clog2(WIDTH+1)-1:0]     cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) cnt_o = cnt_o + {{($clog2(WIDTH+1)-1){1'b0}}, x_i[i]};
    end
endmodule

// File: rtl/popcnt_seq.sv
// popcnt_seq: cpop/cpopw over one shared 32-bit popcount, low chunk then high chunk.
module popcnt_seq import popcnt_seq_pkg::*; #(parameter int XLEN = 64) (
    input logic clk,
    input logic reset,
    popcnt_seq_if.slave bus
);
    state_e state_q, state_d;
    logic [2*CHUNK-1:0] aq_q, aq_d, a_ext;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic word_q, word_d;
    logic [PC_W-1:0] cnt;

    // Narrow builds zero-fill the upper chunk so the mux below stays width-agnostic.
    always_comb begin
        a_ext = '0;
        a_ext[XLEN-1:0] = bus.A;
    end

    popcnt #(.WIDTH(CHUNK)) u_pc (
        .x_i(state_q == HIGH ? aq_q[2*CHUNK-1:CHUNK] : aq_q[CHUNK-1:0]),
        .cnt_o(cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            aq_q <= '0;
            acc_q <= '0;
            word_q <= 1'b0;
        end else begin
            state_q <= state_d;
            aq_q <= aq_d;
            acc_q <= acc_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aq_d = aq_q;
        acc_d = acc_q;
        word_d = word_q;
        if (bus.Flush) state_d = IDLE;
        else case (state_q)
            IDLE: if (bus.ValidIn) begin
                aq_d = a_ext;
                word_d = bus.Word;
                acc_d = '0;
                state_d = LOW;
            end
            LOW: begin
                acc_d = CNT_W'(cnt);
                state_d = (word_q || XLEN == 32) ? DONE : HIGH;
            end
            HIGH: begin
                acc_d = acc_q + CNT_W'(cnt);
                state_d = DONE;
            end
            DONE: state_d = bus.ReadyIn ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ReadyOut = state_q == IDLE && !bus.Flush;
    assign bus.ValidOut = state_q == DONE;
    assign bus.Result = state_q == DONE ? acc_q : '0;
    assign bus.Busy = state_q != IDLE;
endmodule

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq: drives a 64-bit and a 32-bit popcnt_seq with shared stimulus against a countdown model.
module tb_popcnt_seq;
    logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0, word = 1'b0, flush = 1'b0, ready_in = 1'b0;
    logic [63:0] a = '0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    popcnt_seq_if #(.XLEN(64)) b64();
    popcnt_seq_if #(.XLEN(32)) b32();
    assign b64.ValidIn = valid_in;
    assign b64.A = a;
    assign b64.Word = word;
    assign b64.Flush = flush;
    assign b64.ReadyIn = ready_in;
    assign b32.ValidIn = valid_in;
    assign b32.A = a[31:0];
    assign b32.Word = word;
    assign b32.Flush = flush;
    assign b32.ReadyIn = ready_in;

    popcnt_seq #(.XLEN(64)) dut64(.clk(clk), .reset(reset), .bus(b64));
    popcnt_seq #(.XLEN(32)) dut32(.clk(clk), .reset(reset), .bus(b32));

    function automatic void chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
        end
    endfunction

    // Model: each instance is either free or holding a result that appears after
    // a fixed number of edges and leaves on ReadyIn; Flush/reset drop it.
    logic act[2];
    int t[2];
    logic [6:0] res[2];
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] <= 1'b0;
                t[i] <= 0;
                res[i] <= '0;
            end else if (flush) act[i] <= 1'b0;
            else if (!act[i]) begin
                if (valid_in) begin
                    act[i] <= 1'b1;
                    t[i] <= (i == 1 || word) ? 1 : 2;
                    res[i] <= 7'($countones((i == 1 || word) ? {32'b0, a[31:0]} : a));
                end
            end else if (t[i] > 0) t[i] <= t[i] - 1;
            else if (ready_in) act[i] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("valid64", b64.ValidOut, act[0] && t[0] == 0);
            chk("result64", b64.Result, (act[0] && t[0] == 0) ? res[0] : 7'd0);
            chk("ready64", b64.ReadyOut, !act[0] && !flush);
            chk("busy64", b64.Busy, act[0]);
            chk("valid32", b32.ValidOut, act[1] && t[1] == 0);
            chk("result32", b32.Result, (act[1] && t[1] == 0) ? res[1] : 7'd0);
            chk("ready32", b32.ReadyOut, !act[1] && !flush);
            chk("busy32", b32.Busy, act[1]);
        end
    end

    task automatic req(input logic [63:0] av, input logic w);
        a = av;
        word = w;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic settle();
        ready_in = 1'b1;
        valid_in = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 20 && (b64.Busy || b32.Busy); c++) @(posedge clk);
        #1 chk("settle_idle", b64.Busy | b32.Busy, 0);
    endtask

    initial begin
        #3;
        chk("rst_ready64", b64.ReadyOut, 1);
        chk("rst_busy64", b64.Busy, 0);
        chk("rst_valid64", b64.ValidOut, 0);
        chk("rst_result64", b64.Result, 0);
        chk("rst_ready32", b32.ReadyOut, 1);
        #9 reset = 1'b0;
        @(posedge clk);
        #1 ready_in = 1'b1;
        req(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk);
        #1 chk("all_ones_high_not_valid", b64.ValidOut, 0);
        @(posedge clk);
        #1 chk("all_ones_valid", b64.ValidOut, 1);
        chk("all_ones_result", b64.Result, 64);
        @(posedge clk);
        #1 chk("all_ones_back_idle", b64.Busy, 0);
        settle();
        req(64'hFFFF_FFFF_0000_0001, 1'b1);
        @(posedge clk);
        #1 chk("cpopw_valid", b64.ValidOut, 1);
        chk("cpopw_result", b64.Result, 1);
        settle();
        ready_in = 1'b0;
        req(64'h0000_0001_FFFF_FFFF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            #1 chk("hold_valid", b64.ValidOut, 1);
            chk("hold_result", b64.Result, 33);
            chk("hold_ready", b64.ReadyOut, 0);
            chk("hold_busy", b64.Busy, 1);
            @(posedge clk);
        end
        #1 ready_in = 1'b1;
        @(posedge clk);
        #1 chk("hold_release", b64.Busy, 0);
        settle();
        req(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", b64.Busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 chk("flush_no_valid", b64.ValidOut, 0);
        end
        flush = 1'b1;
        valid_in = 1'b1;
        #1 chk("flush_blocks_ready", b64.ReadyOut, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        valid_in = 1'b0;
        chk("flush_not_accepted", b64.Busy, 0);
        settle();
        req(64'h1, 1'b0);
        #2 reset = 1'b1;
        #1 chk("arst_valid", b64.ValidOut, 0);
        chk("arst_result", b64.Result, 0);
        chk("arst_busy", b64.Busy, 0);
        chk("arst_ready", b64.ReadyOut, 1);
        chk("arst_busy32", b32.Busy, 0);
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 chk("arst_no_valid", b64.ValidOut, 0);
        end
        req(64'h1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("post_rst_result", b64.Result, 1);
        settle();
        req(64'h8000_0001, 1'b0);
        @(posedge clk);
        #1 chk("x32_valid", b32.ValidOut, 1);
        chk("x32_result", b32.Result, 2);
        settle();
        valid_in = 1'b1;
        begin
            int l64, l32;
            l64 = -1;
            l32 = -1;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (b64.ReadyOut) begin
                    if (l64 >= 0) chk("gap64", 64'(c - l64), 4);
                    l64 = c;
                end
                if (b32.ReadyOut) begin
                    if (l32 >= 0) chk("gap32", 64'(c - l32), 3);
                    l32 = c;
                end
            end
        end
        settle();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            valid_in = $urandom_range(0, 1) == 1;
            word = $urandom_range(0, 3) == 0;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            ready_in = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 19) == 0;
        end
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
